// File: rtl/hazard_stall_ctrl_pkg.sv
// Opcode/funct constants and stall-FSM encoding for the MIPS hazard and forwarding logic.
// Shared so every stage-control block decodes instructions identically.
package hazard_stall_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] J      = 6'b000010;
  localparam logic [5:0] JAL    = 6'b000011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] SW     = 6'b101011;

  localparam logic [5:0] JR     = 6'b001000;
  localparam logic [5:0] JALR   = 6'b001001;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stallState_t;

  // A nonzero destination that feeds a source operand the ID instruction actually reads.
  function automatic logic destMatch(
    input logic [4:0] dest,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       usesRs,
    input logic       usesRt
  );
    return (dest != 5'd0) && ((usesRs && (dest == rs)) || (usesRt && (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter, one increment per cycle; holds at all-ones.
// Synchronous active-high clear; no flow control.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/flush controller: load-use and branch-operand stalls, cache freeze, perf counters.
// Zero-latency control outputs; cache freeze overrides stalls, stalls override redirects.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       IfId_Opcode,
  input  logic [3:0]       IfId_Funct4b,
  input  logic [4:0]       IfIdRs,
  input  logic [4:0]       IfIdRt,
  input  logic [4:0]       IdExRd,
  input  logic             IdEx_RegWrite,
  input  logic             IdEx_MemRead,
  input  logic [4:0]       ExMemRd,
  input  logic             ExMem_MemRead,
  input  logic             ICache_stall,
  input  logic             DCache_stall,
  input  logic             Id_redirect,
  output logic             PC_en,
  output logic             IfId_en,
  output logic             IfId_flush,
  output logic             IdEx_bubble,
  output logic             Pipe_freeze,
  output logic             Stall_busy,
  output logic [CNT_W-1:0] Stall_cycles,
  output logic [CNT_W-1:0] Freeze_cycles,
  output logic [CNT_W-1:0] Flush_count
);

  stallState_t state, stateNext;
  logic        remain, remainNext;

  logic usesRs, usesRt, brUse;
  logic matchEx, matchMem;
  logic needTwo, needOne;
  logic freeze, stallCycle;

  assign usesRs = (IfId_Opcode != J) && (IfId_Opcode != JAL);
  assign usesRt = (IfId_Opcode == R_TYPE) || (IfId_Opcode == BEQ) ||
                  (IfId_Opcode == BNE)    || (IfId_Opcode == SW);
  // JR/JALR read rs in ID, so they need the operand as early as a branch does.
  assign brUse  = (IfId_Opcode == BEQ) || (IfId_Opcode == BNE) ||
                  ((IfId_Opcode == R_TYPE) &&
                   ((IfId_Funct4b == JR[3:0]) || (IfId_Funct4b == JALR[3:0])));

  assign matchEx  = destMatch(IdExRd,  IfIdRs, IfIdRt, usesRs, usesRt);
  assign matchMem = destMatch(ExMemRd, IfIdRs, IfIdRt, usesRs, usesRt);

  assign needTwo = brUse && IdEx_MemRead && matchEx;
  assign needOne = (IdEx_MemRead && matchEx) ||
                   (brUse && IdEx_RegWrite && matchEx) ||
                   (brUse && ExMem_MemRead && matchMem);

  assign freeze = ICache_stall || DCache_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      remain <= 1'b0;
    end else begin
      state  <= stateNext;
      remain <= remainNext;
    end
  end

  always_comb begin
    stateNext   = state;
    remainNext  = remain;
    PC_en       = 1'b0;
    IfId_en     = 1'b0;
    IfId_flush  = 1'b0;
    Pipe_freeze = 1'b0;
    stallCycle  = 1'b0;

    if (rst) begin
      stateNext  = RUN;
      remainNext = 1'b0;
    end else if (freeze) begin
      // Everything holds, including the FSM, so a stall resumes where it left off.
      Pipe_freeze = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (needTwo || needOne) begin
            stallCycle = 1'b1;
            if (needTwo) begin
              stateNext  = STALL;
              remainNext = 1'b1;
            end
          end else begin
            PC_en      = 1'b1;
            IfId_en    = 1'b1;
            IfId_flush = Id_redirect;
          end
        end
        STALL: begin
          stallCycle = 1'b1;
          remainNext = remain - 1'b1;
          if (remainNext == 1'b0) begin
            stateNext = RUN;
          end
        end
        default: begin
          stateNext  = RUN;
          remainNext = 1'b0;
        end
      endcase
    end
  end

  assign IdEx_bubble = stallCycle;
  assign Stall_busy  = (state == STALL) && !rst;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallCycle),
    .count (Stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) uFreezeCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Pipe_freeze),
    .count (Freeze_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IfId_flush),
    .count (Flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios plus random traffic against a pending-stall model.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opcode;
  logic [3:0] funct4;
  logic [4:0] rs, rt, idExRd, exMemRd;
  logic       idExRegWrite, idExMemRead, exMemMemRead;
  logic       iStall, dStall, redirect;

  logic        pcEnA, ifIdEnA, flushA, bubbleA, freezeA, busyA;
  logic [31:0] stallCntA, freezeCntA, flushCntA;
  logic        pcEnB, ifIdEnB, flushB, bubbleB, freezeB, busyB;
  logic [1:0]  stallCntB, freezeCntB, flushCntB;

  hazard_stall_ctrl dutA (
    .clk(clk), .rst(rst),
    .IfId_Opcode(opcode), .IfId_Funct4b(funct4), .IfIdRs(rs), .IfIdRt(rt),
    .IdExRd(idExRd), .IdEx_RegWrite(idExRegWrite), .IdEx_MemRead(idExMemRead),
    .ExMemRd(exMemRd), .ExMem_MemRead(exMemMemRead),
    .ICache_stall(iStall), .DCache_stall(dStall), .Id_redirect(redirect),
    .PC_en(pcEnA), .IfId_en(ifIdEnA), .IfId_flush(flushA), .IdEx_bubble(bubbleA),
    .Pipe_freeze(freezeA), .Stall_busy(busyA),
    .Stall_cycles(stallCntA), .Freeze_cycles(freezeCntA), .Flush_count(flushCntA)
  );

  hazard_stall_ctrl #(.CNT_W(2)) dutB (
    .clk(clk), .rst(rst),
    .IfId_Opcode(opcode), .IfId_Funct4b(funct4), .IfIdRs(rs), .IfIdRt(rt),
    .IdExRd(idExRd), .IdEx_RegWrite(idExRegWrite), .IdEx_MemRead(idExMemRead),
    .ExMemRd(exMemRd), .ExMem_MemRead(exMemMemRead),
    .ICache_stall(iStall), .DCache_stall(dStall), .Id_redirect(redirect),
    .PC_en(pcEnB), .IfId_en(ifIdEnB), .IfId_flush(flushB), .IdEx_bubble(bubbleB),
    .Pipe_freeze(freezeB), .Stall_busy(busyB),
    .Stall_cycles(stallCntB), .Freeze_cycles(freezeCntB), .Flush_count(flushCntB)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: number of stall cycles still owed, plus plain event tallies.
  int     pending = 0;
  longint stallTot = 0, freezeTot = 0, flushTot = 0;
  bit     cntValid = 1'b0;

  function automatic int stallDemand();
    bit readsRs, readsRt, isBranch, hitEx, hitMem;
    readsRs  = !(opcode == 6'd2 || opcode == 6'd3);
    readsRt  = (opcode == 6'd0 || opcode == 6'd4 || opcode == 6'd5 || opcode == 6'd43);
    isBranch = (opcode == 6'd4 || opcode == 6'd5) ||
               (opcode == 6'd0 && (funct4 == 4'd8 || funct4 == 4'd9));
    hitEx  = (idExRd != 0) && ((readsRs && idExRd == rs) || (readsRt && idExRd == rt));
    hitMem = (exMemRd != 0) && ((readsRs && exMemRd == rs) || (readsRt && exMemRd == rt));
    if (isBranch && idExMemRead && hitEx) return 2;
    if ((idExMemRead && hitEx) || (isBranch && idExRegWrite && hitEx) ||
        (isBranch && exMemMemRead && hitMem)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] sat3(input longint v);
    return (v > 3) ? 32'd3 : 32'(v);
  endfunction

  task automatic step();
    bit ePc, eIfId, eFlush, eBub, eFrz, eBusy;
    int nextPending, n;
    @(negedge clk);
    {ePc, eIfId, eFlush, eBub, eFrz, eBusy} = '0;
    nextPending = pending;
    if (!rst) begin
      eBusy = (pending > 0);
      if (iStall || dStall) begin
        eFrz = 1'b1;
      end else if (pending > 0) begin
        eBub = 1'b1;
        nextPending = pending - 1;
      end else begin
        n = stallDemand();
        if (n > 0) begin
          eBub = 1'b1;
          nextPending = n - 1;
        end else begin
          ePc    = 1'b1;
          eIfId  = 1'b1;
          eFlush = redirect;
        end
      end
    end
    checkVal("PC_en",       32'(pcEnA),   32'(ePc));
    checkVal("IfId_en",     32'(ifIdEnA), 32'(eIfId));
    checkVal("IfId_flush",  32'(flushA),  32'(eFlush));
    checkVal("IdEx_bubble", 32'(bubbleA), 32'(eBub));
    checkVal("Pipe_freeze", 32'(freezeA), 32'(eFrz));
    checkVal("Stall_busy",  32'(busyA),   32'(eBusy));
    checkVal("ctrlNarrow", 32'({pcEnB, ifIdEnB, flushB, bubbleB, freezeB, busyB}),
             32'({ePc, eIfId, eFlush, eBub, eFrz, eBusy}));
    if (cntValid) begin
      checkVal("Stall_cycles",  stallCntA,  32'(stallTot));
      checkVal("Freeze_cycles", freezeCntA, 32'(freezeTot));
      checkVal("Flush_count",   flushCntA,  32'(flushTot));
      checkVal("satStall",  32'(stallCntB),  sat3(stallTot));
      checkVal("satFreeze", 32'(freezeCntB), sat3(freezeTot));
      checkVal("satFlush",  32'(flushCntB),  sat3(flushTot));
    end
    @(posedge clk);
    if (rst) begin
      pending   = 0;
      stallTot  = 0;
      freezeTot = 0;
      flushTot  = 0;
      cntValid  = 1'b1;
    end else begin
      pending   = nextPending;
      stallTot  += eBub;
      freezeTot += eFrz;
      flushTot  += eFlush;
    end
    #1;
  endtask

  task automatic idle();
    opcode = 6'd0; funct4 = 4'd0; rs = 5'd0; rt = 5'd0;
    idExRd = 5'd0; idExRegWrite = 1'b0; idExMemRead = 1'b0;
    exMemRd = 5'd0; exMemMemRead = 1'b0;
    iStall = 1'b0; dStall = 1'b0; redirect = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // beq $5,$0 in ID with lw $5 in EX
  task automatic beqAfterLw();
    idle();
    opcode = 6'd4; rs = 5'd5; rt = 5'd0;
    idExRd = 5'd5; idExRegWrite = 1'b1; idExMemRead = 1'b1;
  endtask

  // the lw has advanced to MEM behind a bubble
  task automatic lwInMem();
    idExRd = 5'd0; idExRegWrite = 1'b0; idExMemRead = 1'b0;
    exMemRd = 5'd5; exMemMemRead = 1'b1;
  endtask

  localparam logic [5:0] OPS [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};
  localparam logic [4:0] REGS [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};

  initial begin
    rst = 1'b1;
    idle();

    // reset values, then free-running
    doReset();
    checkVal("rstStallCnt", stallCntA, 32'd0);
    checkVal("rstFlushCnt", flushCntA, 32'd0);
    step();

    // load-use: add $3,$2,$4 behind lw $2
    doReset();
    opcode = 6'd0; funct4 = 4'd0; rs = 5'd2; rt = 5'd4;
    idExRd = 5'd2; idExRegWrite = 1'b1; idExMemRead = 1'b1;
    step();
    idExRd = 5'd0; idExRegWrite = 1'b0; idExMemRead = 1'b0;
    exMemRd = 5'd2; exMemMemRead = 1'b1;
    step();
    checkVal("ldUseStalls", stallCntA, 32'd1);

    // branch after load with redirect held
    doReset();
    beqAfterLw();
    redirect = 1'b1;
    step();
    lwInMem();
    step();
    exMemRd = 5'd0; exMemMemRead = 1'b0;
    step();
    idle();
    step();
    checkVal("brLdStalls",  stallCntA, 32'd2);
    checkVal("brLdFlushes", flushCntA, 32'd1);

    // jr $31 after addi $31, then with a zero destination
    doReset();
    opcode = 6'd0; funct4 = 4'd8; rs = 5'd31; rt = 5'd0;
    idExRd = 5'd31; idExRegWrite = 1'b1;
    step();
    idExRd = 5'd0; idExRegWrite = 1'b0; exMemRd = 5'd31;
    step();
    checkVal("jrAluStalls", stallCntA, 32'd1);
    doReset();
    opcode = 6'd0; funct4 = 4'd8; rs = 5'd31;
    idExRd = 5'd0; idExRegWrite = 1'b1;
    step();
    checkVal("jrZeroStalls", stallCntA, 32'd0);

    // D-cache freeze during the second stall cycle
    doReset();
    beqAfterLw();
    step();
    lwInMem();
    dStall = 1'b1;
    repeat (3) step();
    checkVal("frzBusyHeld", 32'(busyA), 32'd1);
    dStall = 1'b0;
    step();
    idle();
    step();
    checkVal("frzFreezes", freezeCntA, 32'd3);
    checkVal("frzStalls",  stallCntA,  32'd2);

    // saturation of the narrow instance
    doReset();
    repeat (5) begin
      opcode = 6'd0; rs = 5'd2; rt = 5'd4;
      idExRd = 5'd2; idExMemRead = 1'b1;
      step();
      idle();
      step();
    end
    checkVal("satWide",   stallCntA,        32'd5);
    checkVal("satNarrow", 32'(stallCntB),   32'd3);

    // reset asserted inside STALL
    doReset();
    beqAfterLw();
    step();
    lwInMem();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    step();
    checkVal("midRstBusy", 32'(busyA), 32'd0);

    // random traffic
    doReset();
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      opcode       = OPS[$urandom_range(0, 7)];
      funct4       = ($urandom_range(0, 2) == 0) ? 4'(8 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      rs           = REGS[$urandom_range(0, 4)];
      rt           = REGS[$urandom_range(0, 4)];
      idExRd       = REGS[$urandom_range(0, 4)];
      exMemRd      = REGS[$urandom_range(0, 4)];
      idExRegWrite = 1'($urandom_range(0, 1));
      idExMemRead  = 1'($urandom_range(0, 1));
      exMemMemRead = 1'($urandom_range(0, 1));
      iStall       = ($urandom_range(0, 9) == 0);
      dStall       = ($urandom_range(0, 9) == 0);
      redirect     = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
